flash_rd_burst_split: RTL

FLASH_RD_BURST_SPLIT -- requirements
Module: flash_rd_burst_split

---
 rtl/flash_rd_split_pkg.sv | 24 ++
 rtl/flash_rd_burst_split.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rd_split_pkg.sv
// Shared definitions for the flash read burst splitter: FSM state encoding,
// burst limits and the filler word returned for abandoned beats.
package flash_rd_split_pkg;

    // Longest burst the upstream reader may request, in 32-bit words.
    localparam logic [6:0] MAX_BURST = 7'd64;

    // Word returned for every beat that the flash never delivered.
    localparam logic [31:0] FLUSH_DATA = 32'hFFFF_FFFF;

    // One-hot FSM encoding.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_FLUSH = 4'b1000
    } state_t;

    // A burst length is usable when it is 1..MAX_BURST words.
    function automatic logic burst_len_ok(input logic [6:0] cnt);
        return (cnt != 7'd0) && (cnt <= MAX_BURST);
    endfunction

endpackage

// File: rtl/flash_rd_burst_split.sv
// Splits an upstream burst read into single-word reads towards the flash
// controller, keeps a bounded number of reads in flight, returns the data in
// order with one cycle of latency, and recovers from a silent flash by
// padding the burst with filler words and discarding late responses.
module flash_rd_burst_split
    import flash_rd_split_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 28,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] slv_addr,
    input  logic                  slv_read,
    input  logic [6:0]            slv_burstcnt,
    output logic                  slv_waitreq,
    output logic [31:0]           slv_rddata,
    output logic                  slv_rddvld,
    output logic [ADDR_WIDTH-1:0] mst_addr,
    output logic                  mst_read,
    input  logic                  mst_waitreq,
    input  logic [31:0]           mst_rddata,
    input  logic                  mst_rddvld,
    input  logic                  clr_err,
    output logic [7:0]            status
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [OUT_W-1:0]      OUT_ZERO  = {OUT_W{1'b0}};
    localparam logic [OUT_W-1:0]      OUT_ONE   = OUT_W'(1'b1);
    localparam logic [OUT_W-1:0]      OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [TO_W-1:0]       TO_ZERO   = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]       TO_ONE    = TO_W'(1'b1);
    localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(3'd4);

    state_t                  state_r,        state_s;
    logic [ADDR_WIDTH-1:0]   mst_addr_r,     mst_addr_s;
    logic                    mst_read_r,     mst_read_s;
    logic [6:0]              issue_left_r,   issue_left_s;
    logic [6:0]              beats_left_r,   beats_left_s;
    logic [OUT_W-1:0]        outst_r,        outst_s;
    logic [OUT_W-1:0]        stale_cnt_r,    stale_cnt_s;
    logic [TO_W-1:0]         to_cnt_r,       to_cnt_s;
    logic                    err_timeout_r,  err_timeout_s;
    logic                    err_badburst_r, err_badburst_s;
    logic                    slv_rddvld_r,   slv_rddvld_s;
    logic [31:0]             slv_rddata_r,   slv_rddata_s;

    logic in_idle_s;
    logic active_s;
    logic accept_s;
    logic burst_ok_s;
    logic issue_s;
    logic stale_hit_s;
    logic rsp_s;
    logic timeout_s;

    assign in_idle_s   = (state_r == ST_IDLE);
    assign active_s    = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
    assign accept_s    = in_idle_s && slv_read;
    assign burst_ok_s  = burst_len_ok(slv_burstcnt);
    assign issue_s     = mst_read_r && !mst_waitreq;
    // Responses that belong to a timed-out burst are swallowed first.
    assign stale_hit_s = mst_rddvld && (stale_cnt_r != OUT_ZERO);
    assign rsp_s       = mst_rddvld && (stale_cnt_r == OUT_ZERO) && active_s && (outst_r != OUT_ZERO);
    // Counter is about to reach the limit with nothing happening on the bus.
    assign timeout_s   = active_s && (outst_r != OUT_ZERO) && !mst_rddvld && !issue_s &&
                         (to_cnt_r == TO_LAST);

    // Next-state selection for the burst sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && burst_ok_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (timeout_s) begin
                    state_s = ST_FLUSH;
                end else if (issue_s && (issue_left_r == 7'd1)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (timeout_s) begin
                    state_s = ST_FLUSH;
                end else if (rsp_s && (beats_left_r == 7'd1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (beats_left_r == 7'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of counters, address, error flags and returned data.
    always_comb begin
        mst_addr_s     = mst_addr_r;
        issue_left_s   = issue_left_r;
        beats_left_s   = beats_left_r;
        outst_s        = outst_r;
        to_cnt_s       = to_cnt_r;
        stale_cnt_s    = stale_cnt_r;
        err_timeout_s  = err_timeout_r;
        err_badburst_s = err_badburst_r;
        slv_rddvld_s   = 1'b0;
        slv_rddata_s   = slv_rddata_r;
        mst_read_s     = 1'b0;

        if (clr_err) begin
            err_timeout_s  = 1'b0;
            err_badburst_s = 1'b0;
            stale_cnt_s    = OUT_ZERO;
        end else if (stale_hit_s) begin
            stale_cnt_s = stale_cnt_r - OUT_ONE;
        end else begin
            stale_cnt_s = stale_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s && burst_ok_s) begin
                    mst_addr_s   = slv_addr;
                    issue_left_s = slv_burstcnt;
                    beats_left_s = slv_burstcnt;
                    outst_s      = OUT_ZERO;
                    to_cnt_s     = TO_ZERO;
                end else if (accept_s) begin
                    err_badburst_s = 1'b1;
                end else begin
                    mst_addr_s = mst_addr_r;
                end
            end
            ST_ISSUE, ST_DRAIN: begin
                if (timeout_s) begin
                    // Whatever is still in flight becomes stale; the rest of
                    // the burst is padded from FLUSH.
                    err_timeout_s = 1'b1;
                    stale_cnt_s   = outst_r;
                    outst_s       = OUT_ZERO;
                    to_cnt_s      = TO_ZERO;
                end else begin
                    if (issue_s) begin
                        mst_addr_s   = mst_addr_r + ADDR_STEP;
                        issue_left_s = issue_left_r - 7'd1;
                    end else begin
                        mst_addr_s   = mst_addr_r;
                    end
                    case ({issue_s, rsp_s})
                        2'b10:   outst_s = outst_r + OUT_ONE;
                        2'b01:   outst_s = outst_r - OUT_ONE;
                        default: outst_s = outst_r;
                    endcase
                    if (rsp_s) begin
                        slv_rddvld_s = 1'b1;
                        slv_rddata_s = mst_rddata;
                        beats_left_s = beats_left_r - 7'd1;
                    end else begin
                        slv_rddvld_s = 1'b0;
                    end
                    if (mst_rddvld || issue_s) begin
                        to_cnt_s = TO_ZERO;
                    end else if (outst_r != OUT_ZERO) begin
                        to_cnt_s = to_cnt_r + TO_ONE;
                    end else begin
                        to_cnt_s = to_cnt_r;
                    end
                end
            end
            ST_FLUSH: begin
                slv_rddvld_s = 1'b1;
                slv_rddata_s = FLUSH_DATA;
                beats_left_s = beats_left_r - 7'd1;
            end
            default: begin
                slv_rddvld_s = 1'b0;
            end
        endcase

        // A stalled read stays on the bus untouched; otherwise issue while
        // there is work left and room in the outstanding window.
        if (timeout_s) begin
            mst_read_s = 1'b0;
        end else if (mst_read_r && mst_waitreq) begin
            mst_read_s = 1'b1;
        end else if ((state_s == ST_ISSUE) && (issue_left_s != 7'd0) && (outst_s < OUT_MAX)) begin
            mst_read_s = 1'b1;
        end else begin
            mst_read_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, counter and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mst_addr_r     <= {ADDR_WIDTH{1'b0}};
            mst_read_r     <= 1'b0;
            issue_left_r   <= 7'd0;
            beats_left_r   <= 7'd0;
            outst_r        <= OUT_ZERO;
            stale_cnt_r    <= OUT_ZERO;
            to_cnt_r       <= TO_ZERO;
            err_timeout_r  <= 1'b0;
            err_badburst_r <= 1'b0;
            slv_rddvld_r   <= 1'b0;
            slv_rddata_r   <= 32'h0000_0000;
        end else begin
            mst_addr_r     <= mst_addr_s;
            mst_read_r     <= mst_read_s;
            issue_left_r   <= issue_left_s;
            beats_left_r   <= beats_left_s;
            outst_r        <= outst_s;
            stale_cnt_r    <= stale_cnt_s;
            to_cnt_r       <= to_cnt_s;
            err_timeout_r  <= err_timeout_s;
            err_badburst_r <= err_badburst_s;
            slv_rddvld_r   <= slv_rddvld_s;
            slv_rddata_r   <= slv_rddata_s;
        end
    end

    assign slv_waitreq = !in_idle_s;
    assign slv_rddvld  = slv_rddvld_r;
    assign slv_rddata  = slv_rddata_r;
    assign mst_addr    = mst_addr_r;
    assign mst_read    = mst_read_r;
    assign status      = {5'b00000, err_badburst_r, err_timeout_r, !in_idle_s};

endmodule
